// File: rtl/mm_responder.sv
// mm_responder: main-memory end of the instruction-cache miss handshake.
// A request is latched in IDLE. The FSM waits LATENCY edges in total and then
// returns the addressed word on Data_MM together with a one-cycle Ack_MM.
// Completed responses are counted with saturation.
// Optional feature macro MM_WRITE_EN adds the We_MM/WData_MM write path.
// Without the macro, every request is a read and the array is read-only after reset.
module mm_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req_MM,
  input  logic [31:0] Addr_MM,
`ifdef MM_WRITE_EN
  input  logic        We_MM,
  input  logic [31:0] WData_MM,
`endif
  output logic [31:0] Data_MM,
  output logic        Ack_MM,
  output logic        Busy_MM,
  output logic [19:0] CNT_ACCESS
);

  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIM = 32'(DEPTH * 4);
  localparam logic [31:0] OOR_WORD = 32'hDEADBEEF;
  localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_oor;
  logic [31:0]       r_data;
  logic              r_ack;
  logic              r_busy;
  logic [19:0]       r_acc;
  logic [31:0]       r_mem [DEPTH];
`ifdef MM_WRITE_EN
  logic              r_we;
  logic [31:0]       r_wdata;
`endif

  // Word index and range check come from the live bus at acceptance.
  // The byte offset has no meaning for a word memory.
  logic [ADDR_W-1:0] w_idx;
  logic              w_oor;
  logic              w_unused_addr;

  assign w_idx         = Addr_MM[ADDR_W+1:2];
  assign w_oor         = (Addr_MM >= ADDR_LIM);
  assign w_unused_addr = ^Addr_MM[1:0];

  // Request FSM, backing array and access counter.
  // Reset also reloads the array pattern and aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_data  <= 32'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_acc   <= 20'd0;
`ifdef MM_WRITE_EN
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {16'hA5A5, 16'(i)};
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req_MM) begin
            r_idx   <= w_idx;
            r_oor   <= w_oor;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
`ifdef MM_WRITE_EN
            r_we    <= We_MM;
            r_wdata <= WData_MM;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_ack   <= 1'b1;
            r_state <= S_RESP;
            if (r_acc != CNT_MAX) begin
              r_acc <= r_acc + 20'd1;
            end
`ifdef MM_WRITE_EN
            if (r_oor) begin
              r_data <= OOR_WORD;
            end else if (r_we) begin
              r_mem[r_idx] <= r_wdata;
              r_data       <= r_wdata;
            end else begin
              r_data <= r_mem[r_idx];
            end
`else
            r_data <= r_oor ? OOR_WORD : r_mem[r_idx];
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Req_MM is not looked at here. A held request is taken on the next IDLE edge.
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Data_MM    = r_data;
  assign Ack_MM     = r_ack;
  assign Busy_MM    = r_busy;
  assign CNT_ACCESS = r_acc;

endmodule

// File: tb/tb_mm_responder.sv
// tb_mm_responder: scoreboard bench for mm_responder (default LATENCY=2).
// Expected words are queued when a request is driven. Responses are captured on Ack_MM and then popped.
module tb_mm_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Req_MM = 1'b0;
  logic [31:0] Addr_MM = 32'd0;
`ifdef MM_WRITE_EN
  logic        We_MM = 1'b0;
  logic [31:0] WData_MM = 32'd0;
`endif
  logic [31:0] Data_MM;
  logic        Ack_MM;
  logic        Busy_MM;
  logic [19:0] CNT_ACCESS;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];

  mm_responder #(.LATENCY(LAT), .DEPTH(64), .ADDR_W(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Req_MM     (Req_MM),
    .Addr_MM    (Addr_MM),
`ifdef MM_WRITE_EN
    .We_MM      (We_MM),
    .WData_MM   (WData_MM),
`endif
    .Data_MM    (Data_MM),
    .Ack_MM     (Ack_MM),
    .Busy_MM    (Busy_MM),
    .CNT_ACCESS (CNT_ACCESS)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Response capture: every Ack_MM cycle yields one observed word and its edge number.
  always @(negedge CLK) begin
    if (Ack_MM === 1'b1) begin
      obs_data.push_back(Data_MM);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge CLK); #1;
    RESET = 1'b1;
    Req_MM = 1'b0;
    repeat (2) begin @(negedge CLK); #1; end
    RESET = 1'b0;
    exp_q.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  // Issues one request and holds it until the response arrives. Returns the observed word,
  // the latency in edges from acceptance, and Busy_MM right after acceptance.
  task automatic run_req(input logic [31:0] addr, output logic [31:0] data,
                         output int lat, output logic busy0, output logic tmo);
    int acc;
    bit got;
    Req_MM = 1'b1;
    Addr_MM = addr;
    acc = cyc + 1;
    got = 1'b0;
    busy0 = 1'b0;
    data = 32'd0;
    lat = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK); #1;
      if (k == 0) busy0 = Busy_MM;
      if (obs_data.size() > 0) got = 1'b1;
    end
    Req_MM = 1'b0;
    tmo = !got;
    if (got) begin
      data = obs_data.pop_front();
      lat = obs_cyc.pop_front() - acc;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Data_MM !== 32'd0) begin failures++; $display("FAIL reset_data: got %h required %h", Data_MM, 32'd0); end
    checks++; if (Ack_MM !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b required 0", Ack_MM); end
    checks++; if (Busy_MM !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", Busy_MM); end
    checks++; if (CNT_ACCESS !== 20'd0) begin failures++; $display("FAIL reset_cnt: got %0d required 0", CNT_ACCESS); end
    repeat (3) begin @(negedge CLK); #1; end
    checks++; if (Busy_MM !== 1'b0 || obs_data.size() != 0) begin failures++; $display("FAIL idle_quiet: busy %b acks %0d required 0 0", Busy_MM, obs_data.size()); end
  endtask

  task automatic test_single_read();
    logic [31:0] d, e;
    int lat;
    logic b0, to;
    exp_q.push_back(32'hA5A50002);
    run_req(32'd8, d, lat, b0, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL single_timeout: got no Ack_MM required Ack_MM"); end
    else begin
      checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL single_busy: got %b required 1", b0); end
      checks++; if (d !== e) begin failures++; $display("FAIL single_data: got %h required %h", d, e); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL single_latency: got %0d required %0d", lat, LAT); end
    end
    @(negedge CLK); #1;
    checks++; if (Ack_MM !== 1'b0 || Busy_MM !== 1'b0) begin failures++; $display("FAIL single_pulse: ack %b busy %b required 0 0", Ack_MM, Busy_MM); end
    checks++; if (CNT_ACCESS !== 20'd1) begin failures++; $display("FAIL single_cnt: got %0d required 1", CNT_ACCESS); end
    checks++; if (Data_MM !== e) begin failures++; $display("FAIL single_hold: got %h required %h", Data_MM, e); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d, e;
    int lat;
    logic b0, to;
    exp_q.push_back(32'hDEADBEEF);
    run_req(32'h0000_0103, d, lat, b0, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL oor_timeout: got no Ack_MM required Ack_MM"); end
    else begin
      checks++; if (d !== e) begin failures++; $display("FAIL oor_data: got %h required %h", d, e); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL oor_latency: got %0d required %0d", lat, LAT); end
    end
    @(negedge CLK); #1;
    checks++; if (CNT_ACCESS !== 20'd2) begin failures++; $display("FAIL oor_cnt: got %0d required 2", CNT_ACCESS); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    logic [31:0] d, e;
    int c, prev;
    bit got;
    seq[0] = 32'd0; seq[1] = 32'd4; seq[2] = 32'd0;
    do_reset();
    exp_q.push_back(32'hA5A50000);
    exp_q.push_back(32'hA5A50001);
    exp_q.push_back(32'hA5A50000);
    prev = 0;
    Req_MM = 1'b1;
    Addr_MM = seq[0];
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge CLK); #1;
        if (obs_data.size() > 0) got = 1'b1;
      end
      checks++;
      if (!got) begin
        failures++; $display("FAIL b2b_timeout: got no Ack_MM for request %0d required Ack_MM", k);
        break;
      end
      d = obs_data.pop_front();
      c = obs_cyc.pop_front();
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL b2b_data: request %0d got %h required %h", k, d, e); end
      if (k > 0) begin
        checks++; if (c - prev != LAT + 2) begin failures++; $display("FAIL b2b_spacing: got %0d required %0d", c - prev, LAT + 2); end
      end
      prev = c;
      if (k < 2) Addr_MM = seq[k+1];
      else Req_MM = 1'b0;
    end
    Req_MM = 1'b0;
    @(negedge CLK); #1;
    checks++; if (CNT_ACCESS !== 20'd3) begin failures++; $display("FAIL b2b_cnt: got %0d required 3", CNT_ACCESS); end
    repeat (LAT + 3) begin @(negedge CLK); #1; end
    checks++; if (obs_data.size() != 0) begin failures++; $display("FAIL b2b_extra: got %0d extra acks required 0", obs_data.size()); end
  endtask

  task automatic test_addr_change_busy();
    logic [31:0] d, e;
    bit got;
    exp_q.push_back(32'hA5A50001);
    Req_MM = 1'b1;
    Addr_MM = 32'd4;
    @(negedge CLK); #1;
    checks++; if (Busy_MM !== 1'b1) begin failures++; $display("FAIL hold_busy: got %b required 1", Busy_MM); end
    Addr_MM = 32'd12;
    Req_MM = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge CLK); #1;
      if (obs_data.size() > 0) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL hold_timeout: got no Ack_MM required Ack_MM"); end
    else begin
      d = obs_data.pop_front();
      void'(obs_cyc.pop_front());
      checks++; if (d !== e) begin failures++; $display("FAIL hold_data: got %h required %h", d, e); end
    end
    @(negedge CLK); #1;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d, e;
    int lat;
    logic b0, to;
    Req_MM = 1'b1;
    Addr_MM = 32'd8;
    @(negedge CLK); #1;
    checks++; if (Busy_MM !== 1'b1) begin failures++; $display("FAIL abort_busy_before: got %b required 1", Busy_MM); end
    RESET = 1'b1;
    Req_MM = 1'b0;
    @(negedge CLK); #1;
    checks++; if (Ack_MM !== 1'b0) begin failures++; $display("FAIL abort_ack: got %b required 0", Ack_MM); end
    checks++; if (Busy_MM !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", Busy_MM); end
    checks++; if (Data_MM !== 32'd0) begin failures++; $display("FAIL abort_data: got %h required 0", Data_MM); end
    checks++; if (CNT_ACCESS !== 20'd0) begin failures++; $display("FAIL abort_cnt: got %0d required 0", CNT_ACCESS); end
    RESET = 1'b0;
    repeat (LAT + 4) begin @(negedge CLK); #1; end
    checks++; if (obs_data.size() != 0) begin failures++; $display("FAIL abort_no_ack: got %0d acks required 0", obs_data.size()); end
    obs_data.delete();
    obs_cyc.delete();
    exp_q.push_back(32'hA5A50001);
    run_req(32'd4, d, lat, b0, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL after_abort_timeout: got no Ack_MM required Ack_MM"); end
    else begin
      checks++; if (d !== e) begin failures++; $display("FAIL after_abort_data: got %h required %h", d, e); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL after_abort_latency: got %0d required %0d", lat, LAT); end
    end
    @(negedge CLK); #1;
    checks++; if (CNT_ACCESS !== 20'd1) begin failures++; $display("FAIL after_abort_cnt: got %0d required 1", CNT_ACCESS); end
  endtask

`ifdef MM_WRITE_EN
  task automatic test_write();
    logic [31:0] addrs [5];
    logic [31:0] d, e;
    logic        wes [5];
    logic [31:0] wds [5];
    int lat;
    logic b0, to;
    addrs[0] = 32'd16;        wes[0] = 1'b1; wds[0] = 32'h12345678;
    addrs[1] = 32'd16;        wes[1] = 1'b0; wds[1] = 32'd0;
    addrs[2] = 32'h0000_0400; wes[2] = 1'b1; wds[2] = 32'h55AA55AA;
    addrs[3] = 32'd0;         wes[3] = 1'b0; wds[3] = 32'd0;
    addrs[4] = 32'd16;        wes[4] = 1'b0; wds[4] = 32'd0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) do_reset();
      case (k)
        0, 1:    exp_q.push_back(32'h12345678);
        2:       exp_q.push_back(32'hDEADBEEF);
        3:       exp_q.push_back(32'hA5A50000);
        default: exp_q.push_back(32'hA5A50004);
      endcase
      We_MM = wes[k];
      WData_MM = wds[k];
      run_req(addrs[k], d, lat, b0, to);
      We_MM = 1'b0;
      WData_MM = 32'd0;
      e = exp_q.pop_front();
      checks++;
      if (to) begin failures++; $display("FAIL write_timeout: step %0d got no Ack_MM required Ack_MM", k); end
      else begin
        checks++; if (d !== e) begin failures++; $display("FAIL write_data: step %0d got %h required %h", k, d, e); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL write_latency: step %0d got %0d required %0d", k, lat, LAT); end
      end
      @(negedge CLK); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_out_of_range();
    test_back_to_back();
    test_addr_change_busy();
    test_reset_in_wait();
`ifdef MM_WRITE_EN
    test_write();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
